// File: rtl/call_request_queue.sv
// rtl/call_request_queue.sv - pending floor-call register with SCAN target offer over valid/ack
module call_request_queue #(
  parameter int FLOORS = 4,
  parameter int FW     = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              slowref,
  input  logic [FLOORS-1:0] call_pulse,
  input  logic [FW-1:0]     cur_floor,
  input  logic              dir_up,
  output logic              req_valid,
  output logic [FW-1:0]     req_floor,
  input  logic              req_ack,
  output logic [FLOORS-1:0] pending,
  output logic [FW:0]       pending_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic [FLOORS-1:0]   r_pending;
  logic [FLOORS-1:0]   w_set;
  logic [FLOORS-1:0]   w_clr;
  logic [FW-1:0]       r_req_floor;
  logic [FW-1:0]       w_sel;
  logic [FW-1:0]       w_lo_sel;
  logic [FW-1:0]       w_hi_sel;
  logic                w_lo_hit;
  logic                w_hi_hit;
  logic [FW:0]         w_cnt;
  int                  w_c;

  // Calls are only taken on the slowref strobe; the ack clears the offered floor
  always_comb begin
    w_set = slowref ? call_pulse : '0;
    w_clr = '0;
    if (r_state == OFFER && req_ack) begin
      w_clr[r_req_floor] = 1'b1;
    end
  end

  // Pending register: a set on the same edge as a clear of that floor wins
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  // SCAN selection: lowest candidate at/above and highest at/below the clamped floor
  always_comb begin
    w_c = int'(cur_floor);
    if (w_c >= FLOORS) begin
      w_c = FLOORS - 1;
    end
    w_lo_hit = 1'b0;
    w_lo_sel = '0;
    w_hi_hit = 1'b0;
    w_hi_sel = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (r_pending[i] && (dir_up ? (i >= w_c) : (i > w_c))) begin
        w_lo_hit = 1'b1;
        w_lo_sel = FW'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (dir_up ? (i < w_c) : (i <= w_c))) begin
        w_hi_hit = 1'b1;
        w_hi_sel = FW'(i);
      end
    end
    if (dir_up) begin
      w_sel = w_lo_hit ? w_lo_sel : w_hi_sel;
    end else begin
      w_sel = w_hi_hit ? w_hi_sel : w_lo_sel;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: offer from IDLE when anything is pending, hold until ack
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_state_nxt = OFFER;
          w_load      = 1'b1;
        end
      end
      OFFER: begin
        if (req_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Target floor is latched only on entry to OFFER so it stays stable while offered
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_req_floor <= '0;
    end else if (w_load) begin
      r_req_floor <= w_sel;
    end
  end

  // Population count of the pending register
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < FLOORS; i++) begin
      w_cnt = w_cnt + (FW+1)'(r_pending[i]);
    end
  end

  assign req_valid   = (r_state == OFFER);
  assign req_floor   = r_req_floor;
  assign pending     = r_pending;
  assign pending_cnt = w_cnt;

endmodule
